// File: rtl/nes_gamepad_pkg.sv
// Shared constants and FSM state type for the NES gamepad poller.
package nes_gamepad_pkg;

  localparam logic [1:0] REG_STATUS = 2'd0;
  localparam logic [1:0] REG_CTRL   = 2'd1;
  localparam logic [1:0] REG_EDGE   = 2'd2;

  localparam int unsigned NUM_BTNS  = 8;
  localparam int unsigned BTN_A      = 0;
  localparam int unsigned BTN_B      = 1;
  localparam int unsigned BTN_SELECT = 2;
  localparam int unsigned BTN_START  = 3;
  localparam int unsigned BTN_UP     = 4;
  localparam int unsigned BTN_DOWN   = 5;
  localparam int unsigned BTN_LEFT   = 6;
  localparam int unsigned BTN_RIGHT  = 7;

  typedef enum logic [2:0] {
    IDLE,
    LATCH,
    WAIT0,
    CLK_LO,
    CLK_HI,
    DONE
  } pad_state_e;

endpackage

// File: rtl/nes_gamepad_phy.sv
// Pad serial engine: input synchroniser, latch/clock sequencer and shift register.
module nes_gamepad_phy
  import nes_gamepad_pkg::*;
#(
  parameter int unsigned HALF_BIT_CYCLES = 96
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                start_i,
  input  logic                pad_data_i,
  output logic                pad_latch_o,
  output logic                pad_clk_o,
  output logic                busy_o,
  output logic                done_o,
  output logic [NUM_BTNS-1:0] data_o
);

  localparam int unsigned CW = $clog2(2 * HALF_BIT_CYCLES);
  localparam logic [CW-1:0] LATCH_LAST = CW'(2 * HALF_BIT_CYCLES - 1);
  localparam logic [CW-1:0] HALF_LAST  = CW'(HALF_BIT_CYCLES - 1);

  pad_state_e          state_q;
  logic [CW-1:0]       cnt_q;
  logic [2:0]          bit_q;
  logic [NUM_BTNS-1:0] shift_q;
  logic                sync1_q, sync2_q;
  logic                latch_q, pclk_q, busy_q, done_q;
  logic                cnt_zero;

  assign cnt_zero    = (cnt_q == '0);
  assign pad_latch_o = latch_q;
  assign pad_clk_o   = pclk_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign data_o      = shift_q;

  // Released pad line reads high, so the synchroniser resets to "not pressed".
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= pad_data_i;
      sync2_q <= sync1_q;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      latch_q <= 1'b0;
      pclk_q  <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (state_q != IDLE && !cnt_zero) cnt_q <= cnt_q - CW'(1);
      case (state_q)
        IDLE: if (start_i) begin
          state_q <= LATCH;
          cnt_q   <= LATCH_LAST;
          latch_q <= 1'b1;
          busy_q  <= 1'b1;
        end
        LATCH: if (cnt_zero) begin
          state_q <= WAIT0;
          cnt_q   <= HALF_LAST;
          latch_q <= 1'b0;
        end
        WAIT0: if (cnt_zero) begin
          shift_q <= {7'b0, ~sync2_q};
          bit_q   <= 3'd1;
          state_q <= CLK_LO;
          cnt_q   <= HALF_LAST;
          pclk_q  <= 1'b0;
        end
        CLK_LO: if (cnt_zero) begin
          state_q <= CLK_HI;
          cnt_q   <= HALF_LAST;
          pclk_q  <= 1'b1;
        end
        CLK_HI: if (cnt_zero) begin
          shift_q[bit_q] <= ~sync2_q;
          if (bit_q == 3'd7) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end else begin
            bit_q   <= bit_q + 3'd1;
            state_q <= CLK_LO;
            cnt_q   <= HALF_LAST;
            pclk_q  <= 1'b0;
          end
        end
        // A queued request chains straight into the next latch pulse.
        DONE: if (start_i) begin
          state_q <= LATCH;
          cnt_q   <= LATCH_LAST;
          latch_q <= 1'b1;
        end else begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/nes_gamepad.sv
// iomem peripheral exposing polled NES gamepad buttons to firmware.
// Define NES_GAMEPAD_EDGE_EN to add the sticky newly-pressed EDGE register.
module nes_gamepad
  import nes_gamepad_pkg::*;
#(
  parameter int unsigned CLK_HZ          = 16000000,
  parameter int unsigned POLL_HZ         = 60,
  parameter int unsigned HALF_BIT_CYCLES = 96
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        iomem_valid,
  input  logic [3:0]  iomem_wstrb,
  input  logic [31:0] iomem_addr,
  input  logic [31:0] iomem_wdata,
  output logic        iomem_ready,
  output logic [31:0] iomem_rdata,
  output logic        PAD_LATCH,
  output logic        PAD_CLK,
  input  logic        PAD_DATA
);

  localparam int unsigned POLL_CYCLES = CLK_HZ / POLL_HZ;
  localparam int unsigned TW = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(POLL_CYCLES - 1);

  logic                served_q, served_d;
  logic                ready_q, ready_d;
  logic [31:0]         rdata_q, rdata_d;
  logic                auto_q, auto_d;
  logic                pending_q, pending_d;
  logic [TW-1:0]       timer_q, timer_d;
  logic [NUM_BTNS-1:0] buttons_q, buttons_d;
  logic                valid_q, valid_d;
  logic [15:0]         poll_cnt_q, poll_cnt_d;

  logic                acc_c, wr_c, ctrl_wr_c, req_c, start_c;
  logic [1:0]          off_c;
  logic [31:0]         rd_c;
  logic                busy, done;
  logic [NUM_BTNS-1:0] pad_bits;
  logic                unused_c;

  assign unused_c    = ^{iomem_addr, iomem_wdata, iomem_wstrb};
  assign iomem_ready = ready_q;
  assign iomem_rdata = rdata_q;

  // A transaction is accepted once per assertion of iomem_valid.
  assign acc_c     = iomem_valid & ~served_q;
  assign off_c     = iomem_addr[3:2];
  assign wr_c      = acc_c & (iomem_wstrb != 4'b0);
  assign ctrl_wr_c = wr_c & iomem_wstrb[0] & (off_c == REG_CTRL);
  assign req_c     = (ctrl_wr_c & iomem_wdata[1]) | ((timer_q == '0) & auto_q);
  assign start_c   = (~busy | done) & (req_c | pending_q);

  nes_gamepad_phy #(
    .HALF_BIT_CYCLES(HALF_BIT_CYCLES)
  ) u_phy (
    .clk        (clk),
    .resetn     (resetn),
    .start_i    (start_c),
    .pad_data_i (PAD_DATA),
    .pad_latch_o(PAD_LATCH),
    .pad_clk_o  (PAD_CLK),
    .busy_o     (busy),
    .done_o     (done),
    .data_o     (pad_bits)
  );

`ifdef NES_GAMEPAD_EDGE_EN
  logic [NUM_BTNS-1:0] edge_q, edge_d;
  logic [NUM_BTNS-1:0] edge_clr_c, edge_set_c;

  // Set at DONE takes priority over a same-cycle write-1-to-clear.
  always_comb begin
    edge_clr_c = '0;
    edge_set_c = '0;
    if (wr_c && iomem_wstrb[0] && off_c == REG_EDGE) edge_clr_c = iomem_wdata[7:0];
    if (done) edge_set_c = pad_bits & ~buttons_q;
    edge_d = (edge_q & ~edge_clr_c) | edge_set_c;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) edge_q <= '0;
    else         edge_q <= edge_d;
  end
`endif

  always_comb begin
    rd_c = '0;
    case (off_c)
      REG_STATUS: rd_c = {poll_cnt_q, 7'b0, valid_q, buttons_q};
      REG_CTRL:   rd_c = {29'b0, busy, 1'b0, auto_q};
`ifdef NES_GAMEPAD_EDGE_EN
      REG_EDGE:   rd_c = {24'b0, edge_q};
`endif
      default:    rd_c = '0;
    endcase
  end

  always_comb begin
    served_d   = iomem_valid;
    ready_d    = acc_c;
    rdata_d    = acc_c ? rd_c : '0;
    auto_d     = ctrl_wr_c ? iomem_wdata[0] : auto_q;
    timer_d    = (timer_q == '0) ? TIMER_LAST : timer_q - TW'(1);
    pending_d  = pending_q;
    buttons_d  = buttons_q;
    valid_d    = valid_q;
    poll_cnt_d = poll_cnt_q;
    // DONE consumes both the pending flag and any same-cycle request.
    if (done) pending_d = 1'b0;
    else if (busy && req_c) pending_d = 1'b1;
    if (done) begin
      buttons_d  = pad_bits;
      valid_d    = 1'b1;
      poll_cnt_d = poll_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      served_q   <= 1'b0;
      ready_q    <= 1'b0;
      rdata_q    <= '0;
      auto_q     <= 1'b1;
      pending_q  <= 1'b0;
      timer_q    <= TIMER_LAST;
      buttons_q  <= '0;
      valid_q    <= 1'b0;
      poll_cnt_q <= '0;
    end else begin
      served_q   <= served_d;
      ready_q    <= ready_d;
      rdata_q    <= rdata_d;
      auto_q     <= auto_d;
      pending_q  <= pending_d;
      timer_q    <= timer_d;
      buttons_q  <= buttons_d;
      valid_q    <= valid_d;
      poll_cnt_q <= poll_cnt_d;
    end
  end

endmodule

// File: tb/tb_nes_gamepad.sv
// Self-checking bench for nes_gamepad with a behavioural 4021-style pad model.
module tb_nes_gamepad;

  localparam int H = 96;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        iomem_valid = 1'b0;
  logic [3:0]  iomem_wstrb = 4'h0;
  logic [31:0] iomem_addr = 32'h0;
  logic [31:0] iomem_wdata = 32'h0;
  logic        iomem_ready;
  logic [31:0] iomem_rdata;
  logic        PAD_LATCH, PAD_CLK, PAD_DATA;

  int checks = 0;
  int errors = 0;

  nes_gamepad #(
    .CLK_HZ(16000000),
    .POLL_HZ(4000),
    .HALF_BIT_CYCLES(H)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .iomem_valid(iomem_valid),
    .iomem_wstrb(iomem_wstrb),
    .iomem_addr (iomem_addr),
    .iomem_wdata(iomem_wdata),
    .iomem_ready(iomem_ready),
    .iomem_rdata(iomem_rdata),
    .PAD_LATCH  (PAD_LATCH),
    .PAD_CLK    (PAD_CLK),
    .PAD_DATA   (PAD_DATA)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Pad model: latch loads bit 0, each rising PAD_CLK shifts to the next bit.
  logic [7:0] pad_btn = 8'h09;
  int         pad_idx = 0;
  logic       pad_pclk = 1'b1;
  always @(negedge clk) begin
    if (PAD_LATCH) pad_idx = 0;
    else if (PAD_CLK && !pad_pclk) pad_idx++;
    pad_pclk = PAD_CLK;
  end
  assign PAD_DATA = (pad_idx < 8) ? ~pad_btn[pad_idx[2:0]] : 1'b0;

  // Pin activity monitor.
  int   cyc = 0;
  logic lat_prev = 1'b0, pclk_m = 1'b1;
  int   lat_len = 0, last_lat_len = 0, rises = 0, last_rise_cyc = 0;
  int   last_fall_cyc = 0, last_gap = 0, lo_len = 0, lo_pulses = 0, lo_bad = 0;
  always @(posedge clk) cyc++;
  always @(negedge clk) begin
    if (PAD_LATCH) lat_len++;
    if (PAD_LATCH && !lat_prev) begin
      rises++;
      last_rise_cyc = cyc;
      last_gap = cyc - last_fall_cyc;
    end
    if (!PAD_LATCH && lat_prev) begin
      last_lat_len = lat_len;
      lat_len = 0;
      last_fall_cyc = cyc;
    end
    if (!PAD_CLK) lo_len++;
    if (!PAD_CLK && pclk_m) lo_pulses++;
    if (PAD_CLK && !pclk_m) begin
      if (lo_len != H) lo_bad++;
      lo_len = 0;
    end
    lat_prev = PAD_LATCH;
    pclk_m = PAD_CLK;
  end

  // Read-data scoreboard.
  typedef struct {
    logic        chk;
    logic [31:0] exp;
    string       name;
  } exp_t;
  exp_t sbq[$];
  logic ready_prev = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (ready_prev) begin
      check("ready_one_cycle", 32'(iomem_ready), 32'h0);
      check("rdata_returns_zero", iomem_rdata, 32'h0);
    end
    if (iomem_ready) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ready: rdata 0x%08h with no outstanding access", iomem_rdata);
      end else begin
        e = sbq.pop_front();
        if (e.chk) check(e.name, iomem_rdata, e.exp);
      end
    end
    ready_prev = iomem_ready;
  end

  task automatic bus(input string name, input logic [1:0] off, input logic [3:0] ws,
                     input logic [31:0] wd, input logic chk, input logic [31:0] exp);
    exp_t e;
    int n;
    e.chk = chk;
    e.exp = exp;
    e.name = name;
    @(negedge clk);
    sbq.push_back(e);
    iomem_valid = 1'b1;
    iomem_wstrb = ws;
    iomem_wdata = wd;
    iomem_addr  = 32'h0800_0000 | {28'h0, off, 2'b00};
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!iomem_ready && n < 10);
    if (!iomem_ready) begin
      checks++;
      errors++;
      $display("FAIL %s: no iomem_ready within 10 cycles", name);
      sbq.delete();
    end else begin
      check({name, "_latency"}, 32'(n), 32'd1);
    end
    iomem_valid = 1'b0;
    iomem_wstrb = 4'h0;
  endtask

  task automatic rd(input string name, input logic [1:0] off, input logic [31:0] exp);
    bus(name, off, 4'h0, 32'h0, 1'b1, exp);
  endtask

  task automatic wr(input string name, input logic [1:0] off, input logic [31:0] wd);
    bus(name, off, 4'hF, wd, 1'b0, 32'h0);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  typedef struct {
    string       name;
    logic [1:0]  off;
    logic [3:0]  ws;
    logic [31:0] wd;
    logic        chk;
    logic [31:0] exp;
  } vec_t;

  function automatic vec_t mk(input string n, input logic [1:0] o, input logic [3:0] w,
                              input logic [31:0] d, input logic c, input logic [31:0] e);
    vec_t v;
    v.name = n; v.off = o; v.ws = w; v.wd = d; v.chk = c; v.exp = e;
    return v;
  endfunction

  initial begin
    vec_t tbl[8];
    int base_r, base_lo, base_bad, n, t[3];

    tbl[0] = mk("status_rst", 2'd0, 4'h0, 32'h0, 1'b1, 32'h0000_0000);
    tbl[1] = mk("ctrl_rst",   2'd1, 4'h0, 32'h0, 1'b1, 32'h0000_0001);
    tbl[2] = mk("edge_rst",   2'd2, 4'h0, 32'h0, 1'b1, 32'h0000_0000);
    tbl[3] = mk("rsvd_rd",    2'd3, 4'h0, 32'h0, 1'b1, 32'h0000_0000);
    tbl[4] = mk("rsvd_wr",    2'd3, 4'hF, 32'hFFFF_FFFF, 1'b0, 32'h0);
    tbl[5] = mk("rsvd_rd2",   2'd3, 4'h0, 32'h0, 1'b1, 32'h0000_0000);
    tbl[6] = mk("ctrl_wr_b1", 2'd1, 4'h2, 32'h0000_0000, 1'b0, 32'h0);
    tbl[7] = mk("ctrl_gated", 2'd1, 4'h0, 32'h0, 1'b1, 32'h0000_0001);

    idle(5);
    check("rst_latch", 32'(PAD_LATCH), 32'h0);
    check("rst_clk", 32'(PAD_CLK), 32'h1);
    check("rst_ready", 32'(iomem_ready), 32'h0);
    check("rst_rdata", iomem_rdata, 32'h0);
    resetn = 1'b1;
    idle(2);

    for (int i = 0; i < 8; i++)
      bus(tbl[i].name, tbl[i].off, tbl[i].ws, tbl[i].wd, tbl[i].chk, tbl[i].exp);

    // Triggered poll with A+Start held.
    base_r = rises; base_lo = lo_pulses; base_bad = lo_bad;
    wr("trig1", 2'd1, 32'h2);
    idle(17 * H + 60);
    check("trig1_polls", 32'(rises - base_r), 32'd1);
    check("trig1_latch_len", 32'(last_lat_len), 32'(2 * H));
    check("trig1_clk_pulses", 32'(lo_pulses - base_lo), 32'd7);
    check("trig1_clk_len_bad", 32'(lo_bad - base_bad), 32'd0);
    rd("trig1_status", 2'd0, 32'h0001_0109);
    rd("trig1_ctrl", 2'd1, 32'h0000_0000);

    // Auto polling every 4000 cycles, then disabled.
    wr("auto_on", 2'd1, 32'h1);
    for (int k = 0; k < 3; k++) begin
      n = 0;
      while (rises < base_r + 2 + k && n < 4100) begin
        @(negedge clk);
        n++;
      end
      if (rises < base_r + 2 + k) begin
        checks++;
        errors++;
        $display("FAIL auto_poll_%0d: no latch pulse within 4100 cycles", k);
      end
      t[k] = last_rise_cyc;
    end
    wr("auto_off", 2'd1, 32'h0);
    check("auto_period1", 32'(t[1] - t[0]), 32'd4000);
    check("auto_period2", 32'(t[2] - t[1]), 32'd4000);
    idle(2000);
    rd("auto_status", 2'd0, 32'h0004_0109);
    base_r = rises;
    idle(9000);
    check("auto_stopped", 32'(rises - base_r), 32'd0);

    // Two triggers during an active poll collapse into one chained poll.
    pad_btn = 8'h5A;
    base_r = rises;
    wr("trig2", 2'd1, 32'h2);
    idle(300);
    rd("busy_ctrl", 2'd1, 32'h0000_0004);
    wr("trig2_extra_a", 2'd1, 32'h2);
    wr("trig2_extra_b", 2'd1, 32'h2);
    idle(2 * (17 * H + 1) + 300);
    check("trig2_polls", 32'(rises - base_r), 32'd2);
    check("trig2_chain_gap", 32'(last_gap), 32'(15 * H + 1));
    rd("trig2_status", 2'd0, 32'h0006_015A);

    // Asynchronous reset during the low phase of bit 4.
    base_lo = lo_pulses;
    wr("trig3", 2'd1, 32'h2);
    n = 0;
    while (lo_pulses < base_lo + 4 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("bit4_reached", 32'(lo_pulses - base_lo), 32'd4);
    idle(20);
    resetn = 1'b0;
    #1;
    check("async_rst_clk", 32'(PAD_CLK), 32'h1);
    check("async_rst_latch", 32'(PAD_LATCH), 32'h0);
    idle(4);
    resetn = 1'b1;
    idle(2);
    rd("post_rst_status", 2'd0, 32'h0000_0000);
    rd("post_rst_ctrl", 2'd1, 32'h0000_0001);

`ifdef NES_GAMEPAD_EDGE_EN
    pad_btn = 8'h10;
    wr("edge_trig1", 2'd1, 32'h2);
    idle(17 * H + 60);
    rd("edge_first", 2'd2, 32'h0000_0010);
    rd("edge_status", 2'd0, 32'h0001_0110);
    wr("edge_trig2", 2'd1, 32'h2);
    idle(17 * H + 60);
    rd("edge_sticky", 2'd2, 32'h0000_0010);
    wr("edge_clear", 2'd2, 32'h10);
    rd("edge_cleared", 2'd2, 32'h0000_0000);
`else
    wr("edge_absent_wr", 2'd2, 32'hFF);
    rd("edge_absent_rd", 2'd2, 32'h0000_0000);
`endif

    idle(3);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/nes_gamepad.md
Name: nes_gamepad

Overview:
- iomem-bus peripheral that polls an NES-style serial gamepad (latch/clock/data shift register) and exposes debounced-by-sampling button state to firmware.
- Sits directly downstream of the top-level peripheral decode. Top drives iomem_valid gated with its address-range enable (0x08xx_xxxx). Top muxes this block's iomem_ready/iomem_rdata into the picosoc return path, alongside the gpio and i2c peripherals.

Parameters:
- CLK_HZ, 16000000, core clock frequency in Hz.
- POLL_HZ, 60, auto-poll rate. POLL_CYCLES = CLK_HZ/POLL_HZ (integer division).
- HALF_BIT_CYCLES, 96, clocks per half bit period (6 us at 16 MHz). Must be >= 4.

Ports:
- clk  input  1  core clock.
- resetn  input  1  reset; asynchronous assert, active-low.
- iomem_valid  input  1  transaction request, already gated by the top-level address enable.
- iomem_wstrb  input  4  byte write strobes; 0 means read.
- iomem_addr  input  32  address; only [3:2] decoded.
- iomem_wdata  input  32  write data.
- iomem_ready  output  1  one-cycle transaction acknowledge.
- iomem_rdata  output  32  read data, valid when iomem_ready=1.
- PAD_LATCH  output  1  pad latch strobe, active-high.
- PAD_CLK  output  1  pad shift clock, idle high.
- PAD_DATA  input  1  pad serial data, active-low (0 = pressed), asynchronous.

Behaviour:
- Reset is asynchronous, active-low, all flops. Reset values:
  - PAD_LATCH=0, PAD_CLK=1, iomem_ready=0, iomem_rdata=0.
  - BUTTONS=0, VALID=0, POLL_CNT=0, AUTO=1, pending=0.
  - FSM=IDLE; poll timer loaded with POLL_CYCLES-1.
- Reset mid-poll: bus pins return to idle levels immediately; partial shift data is discarded.
- PAD_DATA passes through a 2-flop synchroniser before use. Sampled bits are inverted so that 1 = pressed.
- Register map (offset = iomem_addr[3:2]):
  - 0x0 STATUS (RO): [7:0] BUTTONS (bit0 A, 1 B, 2 Select, 3 Start, 4 Up, 5 Down, 6 Left, 7 Right); [8] VALID (set after first completed poll); [15:9] 0; [31:16] POLL_CNT (wraps 0xFFFF->0).
  - 0x1 CTRL (RW): [0] AUTO; [1] TRIGGER (write-1 pulse, reads 0); [2] BUSY (RO). Writes apply only when wstrb[0]=1.
  - 0x2 EDGE: see Optional Feature; reads 0 when the feature is absent.
  - 0x3: reserved; reads 0, writes ignored.
- Handshake:
  - iomem_ready rises the cycle after iomem_valid is first seen, lasts exactly 1 cycle, and is not re-asserted until iomem_valid has dropped.
  - iomem_rdata is registered alongside ready and returns to 0 the following cycle.
- Poll timer:
  - Decrements every cycle.
  - At 0: reload POLL_CYCLES-1; if AUTO=1, raise a poll request.
- Poll requests:
  - A request in IDLE starts a poll next cycle.
  - A request while busy sets pending (depth 1; further requests are absorbed). pending starts a poll on the cycle after DONE.
  - Timer and TRIGGER requests in the same cycle produce one poll.
- FSM (H = HALF_BIT_CYCLES, bit index k):
  - IDLE -> LATCH: PAD_LATCH=1 for 2H cycles.
  - LATCH -> WAIT0: PAD_LATCH=0 for H cycles; sample bit0 in the last cycle.
  - WAIT0 -> CLK_LO: PAD_CLK=0 for H cycles.
  - CLK_LO -> CLK_HI: PAD_CLK=1 for H cycles; sample bit k in the last cycle; k++.
  - After bit7 -> DONE. Otherwise -> CLK_LO.
  - DONE (1 cycle): BUTTONS updated atomically from the shift register, VALID=1, POLL_CNT++, then -> IDLE.
  - Total poll length is 17H+1 cycles (1633 at default).
- BUSY=1 in every state except IDLE.
- A STATUS read concurrent with DONE returns the pre-update value.

Optional Feature:
- Macro NES_GAMEPAD_EDGE_EN.
- Defined:
  - EDGE register at 0x2, [7:0] sticky newly-pressed bits. At DONE, EDGE |= new & ~old.
  - Write-1-to-clear, gated by wstrb[0]. A set at DONE wins over a clear in the same cycle for the same bit.
- Undefined: no EDGE flops; offset 0x2 reads 0, writes ignored.

Decomposition:
- Package nes_gamepad_pkg holds:
  - register offset constants (REG_STATUS=0, REG_CTRL=1, REG_EDGE=2);
  - button bit-index constants;
  - FSM state enum (IDLE, LATCH, WAIT0, CLK_LO, CLK_HI, DONE).
- Sub-module nes_gamepad_phy: synchroniser, FSM, shift register, half-bit counter.
  - Inputs: start.
  - Outputs: busy, done pulse, 8-bit data.
- Top nes_gamepad holds the bus front end, poll timer, pending flag and registers.

Test Plan:
- Reset, no traffic: PAD_LATCH=0, PAD_CLK=1; STATUS reads 0x0000_0000; CTRL reads 0x1.
- Model pad holding A+Start (PAD_DATA low on bits 0 and 3); write CTRL=0x2 -> PAD_LATCH high 192 cycles, 7 PAD_CLK low pulses of 96 cycles each; STATUS then reads 0x0001_0109.
- AUTO=1 with POLL_HZ set so POLL_CYCLES=4000 -> poll starts every 4000 cycles; after 3 periods POLL_CNT=3. Write CTRL=0x0 -> no further PAD_LATCH pulses.
- TRIGGER written twice during an active poll -> exactly one extra poll, starting the cycle after DONE; POLL_CNT increments by 2 in total.
- Assert resetn=0 during CLK_LO of bit 4 -> PAD_CLK=1 and PAD_LATCH=0 asynchronously; BUTTONS=0 and VALID=0 after release.
- NES_GAMEPAD_EDGE_EN: press Up across two polls -> EDGE=0x10 after the first poll and stays 0x10 after the second; write EDGE=0x10 -> reads 0x00; iomem_ready lasts 1 cycle for each access.
